// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester of the data-memory arbiter.
// The master modport belongs to the requester (CPU LSU or DMA/debug loader);
// the slave modport belongs to the arbiter.
//   req      request, held until gnt
//   we       1 = store, 0 = load
//   byte_acc 1 = byte access, 0 = word access
//   addr     byte address (only the low ADDR_W bits reach memory)
//   wdata    store data
//   gnt      one-cycle pulse: request accepted, memory cycle in progress
//   rvalid   one-cycle pulse: access complete, rdata valid
//   rdata    load data (byte loads zero-extended), 0 for stores and rejects
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic              byte_acc;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, byte_acc, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, byte_acc, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the byte-addressable
// single-port data memory. Port 0 is the CPU load/store unit, port 1 the
// DMA/debug loader. One access at a time: IDLE -> BUSY -> DONE -> IDLE.
// All outputs are registered.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   m0, m1        requester bundles (dmem_arbiter_if.slave)
//   mem_en        memory write enable, high only in BUSY of a store
//   mem_byte_en   memory byte-access select
//   mem_raddr     memory read address  {0, addr[ADDR_W-1:0]}
//   mem_waddr     memory write address {0, addr[ADDR_W-1:0]}
//   mem_wdata     memory write data
//   mem_rdata     memory read data, combinational from mem_raddr
//   err           pulses with rvalid on a rejected access
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned word
// accesses and word accesses that would run past the top of memory.
// Without it every access reaches memory and err stays 0.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_en,
    output logic              mem_byte_en,
    output logic [31:0]       mem_raddr,
    output logic [31:0]       mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);
    localparam int unsigned PAD_W = 32 - ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;      // port that wins the next contention
    logic              sel_q, sel_d;        // port owning the current access
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic              rej_q, rej_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              men_q, men_d;
    logic              mbyte_q, mbyte_d;
    logic [31:0]       maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              err_q, err_d;

    // Request selection: a lone requester wins outright, contention uses prio.
    logic              any_req_c, both_req_c, pick_c;
    logic              pick_we_c, pick_byte_c, pick_rej_c;
    logic [31:0]       pick_addr_c;
    logic [DATA_W-1:0] pick_wdata_c;
    logic [DATA_W-1:0] load_data_c;
    logic              unused_addr_hi;

    assign any_req_c    = m0.req | m1.req;
    assign both_req_c   = m0.req & m1.req;
    assign pick_c       = both_req_c ? prio_q : m1.req;
    assign pick_we_c    = pick_c ? m1.we       : m0.we;
    assign pick_byte_c  = pick_c ? m1.byte_acc : m0.byte_acc;
    assign pick_addr_c  = pick_c ? m1.addr     : m0.addr;
    assign pick_wdata_c = pick_c ? m1.wdata    : m0.wdata;

    // Upper address bits are dropped: addresses wrap modulo the depth.
    assign unused_addr_hi = ^pick_addr_c[31:ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'((1 << ADDR_W) - 4);
    assign pick_rej_c = ~pick_byte_c &
                        ((pick_addr_c[1:0] != 2'b00) || (pick_addr_c[ADDR_W-1:0] > LAST_WORD));
`else
    assign pick_rej_c = 1'b0;
`endif

    // Data returned in DONE: zero for stores and rejects, byte loads zero-extended.
    assign load_data_c = (we_q | rej_q) ? '0 :
                         byte_q         ? DATA_W'(mem_rdata[7:0]) : mem_rdata;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        sel_d    = sel_q;
        we_d     = we_q;
        byte_d   = byte_q;
        rej_d    = rej_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        rdata0_d = '0;
        rdata1_d = '0;
        men_d    = 1'b0;
        mbyte_d  = 1'b0;
        maddr_d  = '0;
        mwdata_d = '0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    state_d = S_BUSY;
                    if (both_req_c) begin
                        prio_d = ~prio_q;
                    end
                    sel_d  = pick_c;
                    we_d   = pick_we_c;
                    byte_d = pick_byte_c;
                    rej_d  = pick_rej_c;
                    gnt0_d = ~pick_c;
                    gnt1_d = pick_c;
                    // A rejected access runs the sequence with memory lines quiet.
                    if (!pick_rej_c) begin
                        men_d    = pick_we_c;
                        mbyte_d  = pick_byte_c;
                        maddr_d  = {{PAD_W{1'b0}}, pick_addr_c[ADDR_W-1:0]};
                        mwdata_d = pick_wdata_c;
                    end
                end
            end
            S_BUSY: begin
                state_d  = S_DONE;
                rv0_d    = ~sel_q;
                rv1_d    = sel_q;
                rdata0_d = sel_q ? '0 : load_data_c;
                rdata1_d = sel_q ? load_data_c : '0;
                err_d    = rej_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset also aborts an in-flight store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            rej_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            men_q    <= 1'b0;
            mbyte_q  <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            byte_q   <= byte_d;
            rej_q    <= rej_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            men_q    <= men_d;
            mbyte_q  <= mbyte_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            err_q    <= err_d;
        end
    end

    assign m0.gnt      = gnt0_q;
    assign m1.gnt      = gnt1_q;
    assign m0.rvalid   = rv0_q;
    assign m1.rvalid   = rv1_q;
    assign m0.rdata    = rdata0_q;
    assign m1.rdata    = rdata1_q;
    assign mem_en      = men_q;
    assign mem_byte_en = mbyte_q;
    assign mem_raddr   = maddr_q;
    assign mem_waddr   = maddr_q;
    assign mem_wdata   = mwdata_q;
    assign err         = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized two-port
// traffic, checked every cycle against a transaction-level model that tracks
// when the arbiter is free, who wins, and what memory must hold.
module tb_dmem_arbiter;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int          DEPTH  = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W)) m0_if ();
    dmem_arbiter_if #(.DATA_W(DATA_W)) m1_if ();

    logic              mem_en, mem_byte_en, err;
    logic [31:0]       mem_raddr, mem_waddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem_en      (mem_en),
        .mem_byte_en (mem_byte_en),
        .mem_raddr   (mem_raddr),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .err         (err)
    );

    // Requester-side drive variables
    logic        req_v [2];
    logic        we_v  [2];
    logic        bsel_v[2];
    logic [31:0] addr_v[2];
    logic [31:0] wd_v  [2];

    assign m0_if.req = req_v[0];  assign m0_if.we = we_v[0];  assign m0_if.byte_acc = bsel_v[0];
    assign m0_if.addr = addr_v[0]; assign m0_if.wdata = wd_v[0];
    assign m1_if.req = req_v[1];  assign m1_if.we = we_v[1];  assign m1_if.byte_acc = bsel_v[1];
    assign m1_if.addr = addr_v[1]; assign m1_if.wdata = wd_v[1];

    // Byte-addressable memory driven by the DUT, preloaded with mem[i] = i.
    logic [7:0] mem [DEPTH];
    logic       loaded = 1'b0;
    logic [8:0] ra, wa;
    assign ra = mem_raddr[8:0];
    assign wa = mem_waddr[8:0];
    assign mem_rdata = {mem[ra + 9'd3], mem[ra + 9'd2], mem[ra + 9'd1], mem[ra]};

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
            loaded <= 1'b1;
        end else if (mem_en) begin
            mem[wa] <= mem_wdata[7:0];
            if (!mem_byte_en) begin
                mem[wa + 9'd1] <= mem_wdata[15:8];
                mem[wa + 9'd2] <= mem_wdata[23:16];
                mem[wa + 9'd3] <= mem_wdata[31:24];
            end
        end
    end

    // Reference model state
    logic [7:0]  sh [DEPTH];
    int          cyc = 0;
    int          acc_cyc = -100;
    int          acc_port = 0;
    bit          prio = 1'b0;
    bit          m_we, m_byte, m_rej;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    // Scoreboard / observation
    int          vec_n = 0, bad_n = 0;
    bit          rand_mode = 1'b0;
    int          gnt_cyc[2], rv_cyc[2];
    logic [31:0] rv_data[2];
    bit          rv_err[2];
    int          men_cnt = 0, m0_act = 0;
    int          gnt_q[$];
    int          gcyc_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        acc_cyc = -100;
        prio    = 1'b0;
    endtask

    // Decide what the arbiter accepts at the coming clock edge.
    task automatic predict();
        int a;
        int p;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if ((cyc + 1) < acc_cyc + 3 || !(req_v[0] || req_v[1])) return;
        if (req_v[0] && req_v[1]) begin
            p    = int'(prio);
            prio = !prio;
        end else begin
            p = req_v[1] ? 1 : 0;
        end
        acc_cyc  = cyc + 1;
        acc_port = p;
        m_we     = we_v[p];
        m_byte   = bsel_v[p];
        m_wdata  = wd_v[p];
        a        = int'(addr_v[p] % 32'(DEPTH));
        m_addr   = 9'(a);
`ifdef DMEM_ALIGN_CHECK_EN
        m_rej = !m_byte && ((a % 4) != 0 || a > DEPTH - 4);
`else
        m_rej = 1'b0;
`endif
        if (m_we || m_rej)  m_rdata = 32'd0;
        else if (m_byte)    m_rdata = {24'd0, sh[a]};
        else                m_rdata = {sh[(a + 3) % DEPTH], sh[(a + 2) % DEPTH],
                                       sh[(a + 1) % DEPTH], sh[a]};
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic check_cycle();
        bit          busy, done, live;
        logic [31:0] ea, ew;
        busy = (cyc == acc_cyc);
        done = (cyc == acc_cyc + 1);
        live = busy && !m_rej;
        ea   = live ? {23'd0, m_addr} : 32'd0;
        ew   = live ? m_wdata : 32'd0;
        chk("m0_gnt",    64'(m0_if.gnt),    64'(busy && acc_port == 0));
        chk("m1_gnt",    64'(m1_if.gnt),    64'(busy && acc_port == 1));
        chk("m0_rvalid", 64'(m0_if.rvalid), 64'(done && acc_port == 0));
        chk("m1_rvalid", 64'(m1_if.rvalid), 64'(done && acc_port == 1));
        chk("m0_rdata",  64'(m0_if.rdata),  64'((done && acc_port == 0) ? m_rdata : 32'd0));
        chk("m1_rdata",  64'(m1_if.rdata),  64'((done && acc_port == 1) ? m_rdata : 32'd0));
        chk("mem_en",    64'(mem_en),       64'(live && m_we));
        chk("mem_byte",  64'(mem_byte_en),  64'(live && m_byte));
        chk("mem_raddr", 64'(mem_raddr),    64'(ea));
        chk("mem_waddr", 64'(mem_waddr),    64'(ea));
        chk("mem_wdata", 64'(mem_wdata),    64'(ew));
        chk("err",       64'(err),          64'(done && m_rej));
        // The store hit memory at the edge that ended BUSY.
        if (done && m_we && !m_rej) begin
            sh[m_addr] = m_wdata[7:0];
            if (!m_byte) begin
                sh[9'(m_addr + 9'd1)] = m_wdata[15:8];
                sh[9'(m_addr + 9'd2)] = m_wdata[23:16];
                sh[9'(m_addr + 9'd3)] = m_wdata[31:24];
            end
        end
    endtask

    task automatic new_cmd(input int p);
        req_v[p]  = 1'b1;
        we_v[p]   = 1'($urandom_range(0, 1));
        bsel_v[p] = 1'($urandom_range(0, 1));
        wd_v[p]   = $urandom;
        case ($urandom_range(0, 3))
            0:       addr_v[p] = 32'($urandom_range(0, 31));
            1:       addr_v[p] = 32'h1FC + 32'($urandom_range(0, 3));
            2:       addr_v[p] = $urandom;
            default: addr_v[p] = 32'($urandom_range(0, DEPTH - 1));
        endcase
    endtask

    task automatic rand_stim();
        bit g;
        for (int p = 0; p < 2; p++) begin
            g = (p == 0) ? m0_if.gnt : m1_if.gnt;
            if (req_v[p] && g) begin
                if ($urandom_range(0, 3) == 0) new_cmd(p);
                else req_v[p] = 1'b0;
            end else if (!req_v[p] && $urandom_range(0, 2) == 0) begin
                new_cmd(p);
            end
        end
    endtask

    // One clock: predict, advance, check at negedge, record, optional random drive.
    task automatic step();
        predict();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
        if (m0_if.gnt) begin gnt_cyc[0] = cyc; gnt_q.push_back(0); gcyc_q.push_back(cyc); end
        if (m1_if.gnt) begin gnt_cyc[1] = cyc; gnt_q.push_back(1); gcyc_q.push_back(cyc); end
        if (m0_if.rvalid) begin rv_cyc[0] = cyc; rv_data[0] = m0_if.rdata; rv_err[0] = err; end
        if (m1_if.rvalid) begin rv_cyc[1] = cyc; rv_data[1] = m1_if.rdata; rv_err[1] = err; end
        if (mem_en) men_cnt++;
        if (m0_if.gnt || m0_if.rvalid) m0_act++;
        if (rand_mode) rand_stim();
    endtask

    // Single access on port p; returns the cycle in which req was raised.
    task automatic issue(input int p, input bit w, input bit b, input logic [31:0] a,
                         input logic [31:0] d, output int t0);
        int  n;
        bit  g;
        we_v[p] = w; bsel_v[p] = b; addr_v[p] = a; wd_v[p] = d; req_v[p] = 1'b1;
        t0 = cyc;
        n  = 0;
        g  = 1'b0;
        while (!g && n < 20) begin
            step();
            n++;
            g = (p == 0) ? m0_if.gnt : m1_if.gnt;
        end
        if (!g) chk("gnt_timeout", 64'(n), 64'(0));
        req_v[p] = 1'b0;
        step();
        step();
    endtask

    initial begin
        int          t0, e0, diffs, n;
        logic [31:0] exp_word;
        for (int i = 0; i < DEPTH; i++) sh[i] = 8'(i);
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; bsel_v[p] = 1'b0; addr_v[p] = '0; wd_v[p] = '0;
            gnt_cyc[p] = -1; rv_cyc[p] = -1; rv_data[p] = '0; rv_err[p] = 1'b0;
        end

        // Reset state
        repeat (3) step();
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_gnt", 64'({m0_if.gnt, m1_if.gnt}), 64'(0));
        rst_n = 1'b1;
        step();

        // 1: word store then load at 0x10
        e0 = men_cnt;
        issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, t0);
        chk("t1_store_men_cycles", 64'(men_cnt - e0), 64'(1));
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, t0);
        chk("t1_gnt_lat", 64'(gnt_cyc[0] - t0), 64'(1));
        chk("t1_rv_lat", 64'(rv_cyc[0] - t0), 64'(2));
        chk("t1_rdata", 64'(rv_data[0]), 64'(32'hDEADBEEF));

        // 2: byte load on port 1
        e0 = m0_act;
        issue(1, 1'b0, 1'b1, 32'h05, 32'h0, t0);
        chk("t2_rdata", 64'(rv_data[1]), 64'(32'h00000005));
        chk("t2_m0_quiet", 64'(m0_act - e0), 64'(0));

        // 3: contention held for three accesses
        gnt_q.delete();
        gcyc_q.delete();
        we_v[0] = 1'b0; bsel_v[0] = 1'b0; addr_v[0] = 32'h20; req_v[0] = 1'b1;
        we_v[1] = 1'b0; bsel_v[1] = 1'b0; addr_v[1] = 32'h24; req_v[1] = 1'b1;
        n = 0;
        while (gnt_q.size() < 3 && n < 30) begin
            step();
            n++;
        end
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        chk("t3_ngrants", 64'(gnt_q.size()), 64'(3));
        if (gnt_q.size() == 3) begin
            chk("t3_order0", 64'(gnt_q[0]), 64'(0));
            chk("t3_order1", 64'(gnt_q[1]), 64'(1));
            chk("t3_order2", 64'(gnt_q[2]), 64'(0));
            chk("t3_space01", 64'(gcyc_q[1] - gcyc_q[0]), 64'(3));
            chk("t3_space12", 64'(gcyc_q[2] - gcyc_q[1]), 64'(3));
        end
        repeat (3) step();

        // 4: misaligned word store at 0x13
        e0 = men_cnt;
        issue(0, 1'b1, 1'b0, 32'h13, 32'hDEADBEEF, t0);
        exp_word = {mem[9'h16], mem[9'h15], mem[9'h14], mem[9'h13]};
`ifdef DMEM_ALIGN_CHECK_EN
        chk("t4_err", 64'(rv_err[0]), 64'(1));
        chk("t4_men_cycles", 64'(men_cnt - e0), 64'(0));
        chk("t4_mem", 64'(exp_word), 64'(32'h161514DE));
`else
        chk("t4_err", 64'(rv_err[0]), 64'(0));
        chk("t4_men_cycles", 64'(men_cnt - e0), 64'(1));
        chk("t4_mem", 64'(exp_word), 64'(32'hDEADBEEF));
`endif

        // 5: reset during BUSY of a store
        we_v[0] = 1'b1; bsel_v[0] = 1'b0; addr_v[0] = 32'h40; wd_v[0] = 32'h11223344;
        req_v[0] = 1'b1;
        n = 0;
        while (!m0_if.gnt && n < 10) begin
            step();
            n++;
        end
        chk("t5_busy_men", 64'(mem_en), 64'(1));
        rst_n    = 1'b0;
        req_v[0] = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_men", 64'(mem_en), 64'(0));
        chk("t5_rst_gnt", 64'(m0_if.gnt), 64'(0));
        chk("t5_rst_rv", 64'({m0_if.rvalid, m1_if.rvalid}), 64'(0));
        repeat (2) step();
        rst_n = 1'b1;
        issue(1, 1'b0, 1'b0, 32'h40, 32'h0, t0);
        chk("t5_m1_gnt_lat", 64'(gnt_cyc[1] - t0), 64'(1));
        chk("t5_rdata", 64'(rv_data[1]), 64'(32'h43424140));

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (4000) step();
        rand_mode = 1'b0;
        req_v[0]  = 1'b0;
        req_v[1]  = 1'b0;
        repeat (5) step();

        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== sh[i]) diffs++;
        chk("mem_image", 64'(diffs), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
        $finish;
    end
endmodule
